// File: rtl/panel_pkg.sv
// Shared definitions for the LED panel row-scan driver.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
//
// Contents: default panel geometry, scan state enum, pixel bit-index helper,
// column-off drive level helper.
package panel_pkg;

    localparam int DEF_N_ROWS = 5;
    localparam int DEF_N_COLS = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    // Flat bitmap index of row r, column c.
    function automatic int pix_idx(input int r, input int c, input int n_cols);
        return r * n_cols + c;
    endfunction

    // Level driven on an unlit column for the given polarity.
    function automatic logic col_off_level(input bit active_low);
        return active_low ? 1'b1 : 1'b0;
    endfunction

endpackage

// File: rtl/scan_row_timer.sv
// Phase timer and row counter for the scan driver.
// Latency: end_of_phase/last_row are combinational from the registered counters.
// Backpressure: none; counters clear whenever scanning stops.
//
// Ports: clk, reset (sync, active-high), enable, state (current scan state),
//        row_idx (registered row), row_next (row after this edge),
//        end_of_phase (last cycle of BLANK/DRIVE), last_row (row_idx = N_ROWS-1).
module scan_row_timer
    import panel_pkg::*;
#(
    parameter int N_ROWS       = DEF_N_ROWS,
    parameter int DWELL_CYCLES = 1000,
    parameter int BLANK_CYCLES = 16,
    localparam int RW = $clog2(N_ROWS),
    localparam int TW = $clog2(((DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES) + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          enable,
    input  scan_state_t   state,
    output logic [RW-1:0] row_idx,
    output logic [RW-1:0] row_next,
    output logic          end_of_phase,
    output logic          last_row
);

    // With no blank phase the BLANK state is never entered, so its
    // terminal count is a don't-care; clamp it to keep it non-negative.
    localparam logic [TW-1:0] DWELL_LAST = TW'(DWELL_CYCLES - 1);
    localparam logic [TW-1:0] BLANK_LAST = TW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [RW-1:0] ROW_LAST   = RW'(N_ROWS - 1);

    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;

    assign last_row     = (row_idx == ROW_LAST);
    assign end_of_phase = ((state == ST_BLANK) && (timer == BLANK_LAST)) ||
                          ((state == ST_DRIVE) && (timer == DWELL_LAST));

    always_comb begin
        row_next  = row_idx;
        timer_nxt = timer + TW'(1);
        if (!enable || (state == ST_IDLE)) begin
            row_next  = '0;
            timer_nxt = '0;
        end else if (end_of_phase) begin
            timer_nxt = '0;
            if (state == ST_DRIVE) begin
                row_next = last_row ? '0 : row_idx + RW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            row_idx <= '0;
            timer   <= '0;
        end else begin
            row_idx <= row_next;
            timer   <= timer_nxt;
        end
    end

endmodule

// File: rtl/led_matrix_scan_driver.sv
// Row-scan LED matrix driver with double-buffered, tear-free frame update.
// Latency: outputs registered; they reflect the scan state entered at the same edge.
// Backpressure: none; load always accepted, last load before a frame boundary wins.
//
// Ports: clk, reset (sync, active-high), enable (0 = panel dark),
//        load/pixel_in (capture bitmap into shadow, bit r*N_COLS+c),
//        row_sel (one-hot row drive), col_out (column drive, polarity per
//        COL_ACTIVE_LOW), pending (shadow not yet shown), frame_done (pulse).
module led_matrix_scan_driver
    import panel_pkg::*;
#(
    parameter int N_ROWS         = DEF_N_ROWS,
    parameter int N_COLS         = DEF_N_COLS,
    parameter int DWELL_CYCLES   = 1000,
    parameter int BLANK_CYCLES   = 16,
    parameter bit COL_ACTIVE_LOW = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     load,
    input  logic [N_ROWS*N_COLS-1:0] pixel_in,
    output logic [N_ROWS-1:0]        row_sel,
    output logic [N_COLS-1:0]        col_out,
    output logic                     pending,
    output logic                     frame_done
);

    localparam int RW = $clog2(N_ROWS);
    localparam int NP = N_ROWS * N_COLS;
    localparam logic [N_COLS-1:0] COL_OFF = {N_COLS{col_off_level(COL_ACTIVE_LOW)}};
    // First state after leaving IDLE or finishing a row.
    localparam scan_state_t ST_ROW_START = (BLANK_CYCLES > 0) ? ST_BLANK : ST_DRIVE;

    scan_state_t   state;
    scan_state_t   state_nxt;
    logic [RW-1:0] row_idx;
    logic [RW-1:0] row_next;
    logic          end_of_phase;
    logic          last_row;

    logic [NP-1:0]     active;
    logic [NP-1:0]     shadow;
    logic [NP-1:0]     active_nxt;
    logic              swap;
    logic              frame_end;
    logic [N_COLS-1:0] lit;
    logic [N_COLS-1:0] col_nxt;
    logic [N_ROWS-1:0] row_sel_nxt;

    scan_row_timer #(
        .N_ROWS       (N_ROWS),
        .DWELL_CYCLES (DWELL_CYCLES),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_timer (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .state        (state),
        .row_idx      (row_idx),
        .row_next     (row_next),
        .end_of_phase (end_of_phase),
        .last_row     (last_row)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (enable) state_nxt = ST_ROW_START;
            ST_BLANK: if (!enable) state_nxt = ST_IDLE;
                      else if (end_of_phase) state_nxt = ST_DRIVE;
            ST_DRIVE: if (!enable) state_nxt = ST_IDLE;
                      else if (end_of_phase) state_nxt = ST_ROW_START;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Frame boundaries are the only points where active may change: leaving
    // IDLE, or completing the last row while still enabled.
    assign frame_end  = enable && (state == ST_DRIVE) && end_of_phase && last_row;
    assign swap       = pending && (frame_end || (enable && (state == ST_IDLE)));
    assign active_nxt = swap ? shadow : active;

    // Outputs are built from next-cycle state so the registered drive lines
    // up with the state register rather than lagging it by a cycle.
    always_comb begin
        lit = '0;
        for (int r = 0; r < N_ROWS; r++) begin
            if (row_next == RW'(r)) lit = active_nxt[pix_idx(r, 0, N_COLS) +: N_COLS];
        end
        row_sel_nxt = '0;
        col_nxt     = COL_OFF;
        if (state_nxt == ST_DRIVE) begin
            row_sel_nxt = N_ROWS'(1) << row_next;
            col_nxt     = COL_ACTIVE_LOW ? ~lit : lit;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            active     <= '0;
            shadow     <= '0;
            pending    <= 1'b0;
            frame_done <= 1'b0;
            row_sel    <= '0;
            col_out    <= COL_OFF;
        end else begin
            state      <= state_nxt;
            active     <= active_nxt;
            frame_done <= frame_end;
            row_sel    <= row_sel_nxt;
            col_out    <= col_nxt;
            // A load coinciding with a swap lands in shadow after the old
            // contents were handed to active, so pending stays set.
            if (load) begin
                shadow  <= pixel_in;
                pending <= 1'b1;
            end else if (swap) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_led_matrix_scan_driver.sv
// Randomized self-checking bench for led_matrix_scan_driver against a
// frame-position reference model (cycle count since scan start).
// Ports exercised: all DUT ports.
module tb_led_matrix_scan_driver;

    localparam int NR    = 5;
    localparam int NC    = 7;
    localparam int DWELL = 4;
    localparam int BLANK = 2;
    localparam int ROWP  = DWELL + BLANK;
    localparam int FRAME = NR * ROWP;

    logic            clk;
    logic            reset;
    logic            enable;
    logic            load;
    logic [NR*NC-1:0] pixel_in;
    logic [NR-1:0]   row_sel;
    logic [NC-1:0]   col_out;
    logic            pending;
    logic            frame_done;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit               m_run;
    int               m_k;
    logic [NR*NC-1:0] m_active;
    logic [NR*NC-1:0] m_shadow;
    bit               m_pending;
    bit               m_fd;

    led_matrix_scan_driver #(
        .N_ROWS         (NR),
        .N_COLS         (NC),
        .DWELL_CYCLES   (DWELL),
        .BLANK_CYCLES   (BLANK),
        .COL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .load       (load),
        .pixel_in   (pixel_in),
        .row_sel    (row_sel),
        .col_out    (col_out),
        .pending    (pending),
        .frame_done (frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%0h want=%0h", tag, $time, obs, exp);
        end
    endtask

    // Apply the rules for one clock edge using the inputs the DUT sampled.
    task automatic model_edge();
        bit swap;
        swap = 0;
        m_fd = 0;
        if (reset) begin
            m_run = 0; m_k = 0; m_active = '0; m_shadow = '0; m_pending = 0;
            return;
        end
        if (!enable) begin
            m_run = 0;
            m_k   = 0;
        end else if (!m_run) begin
            m_run = 1;
            m_k   = 0;
            swap  = m_pending;
        end else begin
            m_k++;
            if (m_k % FRAME == 0) begin
                m_fd = 1;
                swap = m_pending;
            end
        end
        if (swap) begin
            m_active  = m_shadow;
            m_pending = 0;
        end
        if (load) begin
            m_shadow  = pixel_in;
            m_pending = 1;
        end
    endtask

    task automatic compare_outputs();
        int pos, row, ph;
        logic [NR-1:0] e_row;
        logic [NC-1:0] e_col;
        e_row = '0;
        e_col = '1;
        if (m_run) begin
            pos = m_k % FRAME;
            row = pos / ROWP;
            ph  = pos % ROWP;
            if (ph >= BLANK) begin
                e_row = NR'(1) << row;
                e_col = ~m_active[row*NC +: NC];
            end
        end
        chk("row_sel", 32'(row_sel), 32'(e_row));
        chk("col_out", 32'(col_out), 32'(e_col));
        chk("pending", 32'(pending), 32'(m_pending));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic rand_pixels();
        pixel_in = 35'({$urandom(), $urandom()});
    endtask

    initial begin
        logic [NR*NC-1:0] pat;
        int off_cnt;
        reset = 1'b1; enable = 1'b0; load = 1'b0; pixel_in = '0;
        m_run = 0; m_k = 0; m_active = '0; m_shadow = '0; m_pending = 0; m_fd = 0;
        repeat (3) step();
        reset = 1'b0;
        step();

        // Directed: corner pixels loaded while idle, then enable.
        pat = '0;
        pat[0] = 1'b1;
        pat[4*NC + 6] = 1'b1;
        pixel_in = pat; load = 1'b1;
        step();
        load = 1'b0;
        step();
        chk("pending_idle_load", 32'(pending), 32'd1);
        enable = 1'b1;
        repeat (2 * FRAME) step();

        // Randomized traffic: loads (biased toward frame boundaries),
        // enable drops, and occasional resets.
        off_cnt = 0;
        for (int i = 0; i < 4000; i++) begin
            load = 1'b0;
            reset = 1'b0;
            if (m_run && ((m_k + 1) % FRAME == 0) && ($urandom_range(0, 2) == 0)) load = 1'b1;
            else if ($urandom_range(0, 14) == 0) load = 1'b1;
            if (load) rand_pixels();
            if (off_cnt > 0) begin
                off_cnt--;
                enable = 1'b0;
            end else begin
                enable = 1'b1;
                if ($urandom_range(0, 120) == 0) off_cnt = $urandom_range(1, 6);
            end
            if ($urandom_range(0, 700) == 0) reset = 1'b1;
            step();
        end

        // Directed: reset mid-DRIVE with a pending frame clears everything.
        reset = 1'b0; load = 1'b0; enable = 1'b1;
        while (!(m_run && (m_k % ROWP) == BLANK + 1)) step();
        pixel_in = '1; load = 1'b1;
        step();
        load = 1'b0;
        chk("pending_before_reset", 32'(pending), 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (FRAME + 3) step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
